// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared constants and helpers for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int PRESCALE_MIN = 8;
    localparam int BIT_CNT_W    = 4;
    localparam int BIT_CNT_MAX  = 15;

    localparam int RATIO_X8     = 8;
    localparam int RATIO_X16    = 16;
    localparam int RATIO_X32    = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync2
// Brief    : Two-flop synchroniser, resets to the idle-high line level.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : UART RX oversampling front end: sync, edge/bit counting and
//            3-sample majority vote. Optional macro UART_RX_GLITCH_FLAG_EN
//            adds the sample_noisy output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cnt_en,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
`ifdef UART_RX_GLITCH_FLAG_EN
    ,
    output logic                  sample_noisy
`endif
);

    localparam logic [PRESCALE_W-1:0] c_EDGE_ONE  = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] c_RATIO_MIN = PRESCALE_W'(PRESCALE_MIN);
    localparam logic [PRESCALE_W-1:0] c_RATIO_RST = PRESCALE_W'(RATIO_X8);
    localparam logic [BIT_CNT_W-1:0]  c_BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  c_BIT_MAX   = BIT_CNT_W'(BIT_CNT_MAX);

    logic                  w_rx_s;
    logic                  w_rise;
    logic [PRESCALE_W-1:0] w_clamped;
    logic [PRESCALE_W-1:0] w_ratio;
    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_last;
    logic                  w_vote;

    logic                  r_cnt_en_d;
    logic [PRESCALE_W-1:0] r_ratio;
    logic                  r_s0;
    logic                  r_s1;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_sampled_bit;
    logic                  r_sample_valid;

    uart_rx_sync2 u_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (RX_IN),
        .o_q (w_rx_s)
    );

    // On the enable rise the fresh prescale is used directly, so the very
    // first bit period already counts with the newly latched ratio.
    assign w_rise    = cnt_en & ~r_cnt_en_d;
    assign w_clamped = (prescale < c_RATIO_MIN) ? c_RATIO_MIN : prescale;
    assign w_ratio   = w_rise ? w_clamped : r_ratio;
    assign w_mid     = w_ratio >> 1;
    assign w_last    = w_ratio - c_EDGE_ONE;
    assign w_vote    = maj3(r_s0, r_s1, w_rx_s);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt_en_d     <= 1'b0;
            r_ratio        <= c_RATIO_RST;
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_edge_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_sampled_bit  <= 1'b1;
            r_sample_valid <= 1'b0;
        end else begin
            r_cnt_en_d <= cnt_en;
            if (w_rise) begin
                r_ratio <= w_clamped;
            end

            if (!cnt_en) begin
                r_edge_cnt     <= '0;
                r_bit_cnt      <= '0;
                r_sample_valid <= 1'b0;
            end else begin
                if (r_edge_cnt == w_last) begin
                    r_edge_cnt <= '0;
                    if (r_bit_cnt != c_BIT_MAX) begin
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                    end
                end else begin
                    r_edge_cnt <= r_edge_cnt + c_EDGE_ONE;
                end

                if (r_edge_cnt == w_mid - c_EDGE_ONE) begin
                    r_s0 <= w_rx_s;
                end
                if (r_edge_cnt == w_mid) begin
                    r_s1 <= w_rx_s;
                end

                r_sample_valid <= (r_edge_cnt == w_mid + c_EDGE_ONE);
                if (r_edge_cnt == w_mid + c_EDGE_ONE) begin
                    r_sampled_bit <= w_vote;
                end
            end
        end
    end

`ifdef UART_RX_GLITCH_FLAG_EN
    logic r_sample_noisy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sample_noisy <= 1'b0;
        end else if (cnt_en && (r_edge_cnt == w_mid + c_EDGE_ONE)) begin
            r_sample_noisy <= !((r_s0 == r_s1) && (r_s1 == w_rx_s));
        end
    end

    assign sample_noisy = r_sample_noisy;
`endif

    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;
    assign edge_cnt     = r_edge_cnt;
    assign bit_cnt      = r_bit_cnt;

endmodule
`default_nettype wire
